// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the segmented multi-cycle adder/subtractor.
//   - state_t   : FSM state encoding (IDLE, RUN, DONE), 2 bits wide.
//   - idx_width : width of the segment-index register for a given segment
//                 count. Never returns less than 1 bit, so a single-segment
//                 build still has a legal vector.
// -----------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int nseg);
    return (nseg <= 1) ? 1 : $clog2(nseg);
  endfunction

endpackage

// File: rtl/seg_adder.sv
// -----------------------------------------------------------------------------
// seg_adder
//   Combinational W-bit ripple-carry adder. Used as the per-cycle adder slice.
// Ports
//   a, b      in  W  addends
//   cin       in  1  carry into bit 0
//   s         out W  sum bits
//   cout      out 1  carry out of bit W-1
//   c_msb_in  out 1  carry into bit W-1 (for two's-complement overflow)
// -----------------------------------------------------------------------------
module seg_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  // c[i] is the carry into bit i; c[W] is the carry out of the slice.
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1] = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
  end

  assign cout     = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/seq_segment_adder.sv
// -----------------------------------------------------------------------------
// seq_segment_adder
//   Multi-cycle adder/subtractor. Operands are captured on the accepting edge,
//   then processed SEG_W bits per clock through a single seg_adder slice, with
//   the inter-segment carry held in a register. The result is presented with a
//   valid/ready handshake and held until the consumer takes it.
// Parameters
//   WIDTH   operand/result width (must be a multiple of SEG_W)
//   SEG_W   bits processed per clock
//   SUB_EN  1: sub input honoured, 0: add-only
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operand request
//   in_ready   out  1      high in IDLE (and never while rst_n is low)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry-in, add mode only
//   sub        in   1      1: a - b, 0: a + b + cin
//   out_valid  out  1      result available (DONE)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result modulo 2**WIDTH
//   cout       out  1      carry out of MSB (subtract: 1 = no borrow)
//   ovf        out  1      two's-complement overflow
// -----------------------------------------------------------------------------
module seq_segment_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SEG_W  = 4,
  parameter int SUB_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG  = WIDTH / SEG_W;
  localparam int IDX_W = idx_width(NSEG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

  if ((SEG_W < 1) || (SEG_W > WIDTH) || ((WIDTH % SEG_W) != 0)) begin : g_param_check
    $error("seq_segment_adder: WIDTH must be a positive multiple of SEG_W");
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;       // already inverted for subtraction
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  // Subtraction is only honoured when the build enables it.
  logic sub_eff;
  assign sub_eff = (SUB_EN != 0) ? sub : 1'b0;

  // ---------------------------------------------------------------------------
  // Segment views of the latched operands
  // ---------------------------------------------------------------------------
  logic [SEG_W-1:0] a_seg [NSEG];
  logic [SEG_W-1:0] b_seg [NSEG];

  for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
    assign a_seg[gi] = a_q[gi*SEG_W +: SEG_W];
    assign b_seg[gi] = b_q[gi*SEG_W +: SEG_W];
  end

  // Select the active segment with an explicit compare per segment; this keeps
  // the mux well-defined even when IDX_W can encode more values than NSEG.
  logic [SEG_W-1:0] cur_a;
  logic [SEG_W-1:0] cur_b;

  always_comb begin
    cur_a = '0;
    cur_b = '0;
    for (int k = 0; k < NSEG; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_a = a_seg[k];
        cur_b = b_seg[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle adder slice
  // ---------------------------------------------------------------------------
  logic [SEG_W-1:0] seg_s;
  logic             seg_cout;
  logic             seg_c_msb_in;

  seg_adder #(
    .W (SEG_W)
  ) u_seg_adder (
    .a        (cur_a),
    .b        (cur_b),
    .cin      (carry_q),
    .s        (seg_s),
    .cout     (seg_cout),
    .c_msb_in (seg_c_msb_in)
  );

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          // a - b is computed as a + ~b + 1; cin plays no part then.
          b_d     = sub_eff ? ~b : b;
          carry_d = sub_eff ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int k = 0; k < NSEG; k++) begin
          if (idx_q == IDX_W'(k)) begin
            sum_d[k*SEG_W +: SEG_W] = seg_s;
          end
        end
        carry_d = seg_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // The top segment's carries give the flags for the whole word.
          cout_d  = seg_cout;
          ovf_d   = seg_c_msb_in ^ seg_cout;
          idx_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // in_ready is gated by rst_n so no operand is offered while reset is held.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_segment_adder.sv
module tb_seq_segment_adder;

  localparam int WIDTH = 16;
  localparam int SEG_W = 4;
  localparam int NSEG  = WIDTH / SEG_W;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  seq_segment_adder #(
    .WIDTH  (WIDTH),
    .SEG_W  (SEG_W),
    .SUB_EN (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input logic sv);
    exp_t r;
    int   ua = int'(av);
    int   ub = int'(bv);
    int   sa = int'($signed(av));
    int   sb = int'($signed(bv));
    int   total;
    int   stotal;
    if (sv) begin
      total  = ua - ub;
      stotal = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      total  = ua + ub + int'(cv);
      stotal = sa + sb + int'(cv);
      r.cout = (total > 65535);
    end
    r.sum = total[WIDTH-1:0];
    r.ovf = (stotal > 32767) || (stotal < -32768);
    return r;
  endfunction

  // Monitor: compares every accepted result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_txn++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn %0d: sum=%h cout=%b ovf=%b (expected sum=%h cout=%b ovf=%b)",
                 n_txn, sum, cout, ovf, e.sum, e.cout, e.ovf);
        chk("sum",  32'(sum),  32'(e.sum));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("ovf",  32'(ovf),  32'(e.ovf));
      end
    end
  end

  // Waits for in_ready, presents one operand set and returns just after the
  // accepting edge with junk on the operand inputs.
  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic cv, input logic sv);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = av; b = bv; cin = cv; sub = sv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    cin = 1'($urandom); sub = 1'($urandom);
  endtask

  // Waits for out_valid (checking latency from the accept edge), then for the
  // handshake to complete. Returns just after the edge that leaves DONE, or at
  // the first out_valid negedge when stop_at_valid is set.
  task automatic wait_done(input bit rand_ready, input bit stop_at_valid);
    int edges = 0;
    bit seen  = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom);
      edges++;
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    chk("latency_edges", 32'(edges), 32'(NSEG));
    if (stop_at_valid) return;
    for (int i = 0; i < 40 && !(out_valid === 1'b1 && out_ready === 1'b1); i++) begin
      @(posedge clk);
      #1;
      out_ready = (i > 6) ? 1'b1 : 1'($urandom);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  initial begin
    exp_t e;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic             rs;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       32'(sum),       32'd0);
    chk("rst_cout",      32'(cout),      32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Directed cases with expected values fixed up front
    exp_q.push_back('{16'hF7D6, 1'b0, 1'b0});
    issue(16'hA51B, 16'h52BB, 1'b0, 1'b0);
    wait_done(0, 0);
    exp_q.push_back('{16'hFFFF, 1'b1, 1'b0});
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    wait_done(0, 0);
    exp_q.push_back('{16'h8000, 1'b0, 1'b1});
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(0, 0);
    exp_q.push_back('{16'hFFFE, 1'b0, 1'b0});
    issue(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_done(0, 0);
    exp_q.push_back('{16'h7FFF, 1'b1, 1'b1});
    issue(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_done(0, 0);

    // Backpressure: result held in DONE, new requests refused
    out_ready = 1'b0;
    exp_q.push_back('{16'h2345, 1'b0, 1'b0});
    issue(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_done(0, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'b0;
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_sum_held",  32'(sum),       32'h2345);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_release_in_ready",  32'(in_ready),  32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    repeat (6) @(negedge clk);
    chk("bp_no_ghost_op", 32'(out_valid), 32'd0);

    // Reset during RUN aborts the operation
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum",       32'(sum),       32'd0);
    chk("midrst_cout",      32'(cout),      32'd0);
    chk("midrst_ovf",       32'(ovf),       32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    exp_q.push_back('{16'h0002, 1'b0, 1'b0});
    issue(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_done(0, 0);

    // Randomized operations with random consumer backpressure
    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (n % 8 == 0) rb = ra;
      e = model(ra, rb, rc, rs);
      exp_q.push_back(e);
      issue(ra, rb, rc, rs);
      wait_done(1, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
